ram_4096_dp: RTL and testbench

Simple dual-port synchronous RAM of 4096 words × 64 bits. It has one independent write port and one independent read port, both on a single clock. It is the storage element exercised by the RAM verification environment, and it sits behind the `ram_if` interface bundle. Reads are registered with a fixed one-cycle latency; a per-word valid bit makes unwritten locations read as zero.

---
 rtl/ram_4096_dp.sv | 50 +++++
 tb/tb_ram_4096_dp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_4096_dp.sv
// Simple dual-port synchronous RAM, one write port and one registered read port on one clock.
// Define RAM_BYPASS_EN for write-first collisions; the default build is read-first.
module ram_4096_dp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out
);

  if (DEPTH != 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("ram_4096_dp: DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [DATA_WIDTH-1:0] rd_word;

  // Invalid words read as zero, which hides whatever mem still holds after a reset.
  always_comb begin
    rd_word = vld[rd_address] ? mem[rd_address] : '0;
`ifdef RAM_BYPASS_EN
    if (write && (wr_address == rd_address)) rd_word = data_in;
`endif
  end

  // NOTE: the data array is deliberately left out of reset; clearing the valid
  // bits is enough to make stale contents unobservable and keeps mem a plain RAM.
  always_ff @(posedge clk) begin
    if (resetn && write) mem[wr_address] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld      <= '0;
      data_out <= '0;
    end else begin
      if (write) vld[wr_address] <= 1'b1;
      if (read)  data_out        <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_4096_dp.sv
// Self-checking bench for ram_4096_dp: directed vector table followed by random traffic
// checked against a behavioural model through an expected-value queue.
module tb_ram_4096_dp;
  localparam int DW = 64;
  localparam int AW = 12;
`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, write, read;
  logic [AW-1:0] wr_address, rd_address;
  logic [DW-1:0] data_in, data_out;

  always #5 clk = ~clk;

  ram_4096_dp dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .wr_address(wr_address),
    .write(write), .rd_address(rd_address), .read(read), .data_out(data_out)
  );

  typedef struct {
    logic          resetn;
    logic          write;
    logic [AW-1:0] wa;
    logic [DW-1:0] din;
    logic          read;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] exp_q[$];
  int            applied = 0;
  int            miscompares = 0;

  logic [DW-1:0] m_mem [4096];
  bit            m_vld [4096];
  logic [DW-1:0] m_out = '0;

  task automatic add(input logic rn, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] din, input logic rd, input logic [AW-1:0] ra,
                     input logic [DW-1:0] exp);
    vec_t v;
    v.resetn = rn; v.write = w; v.wa = wa; v.din = din;
    v.read = rd; v.ra = ra; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus and advance the reference model by that edge.
  task automatic drive(input logic rn, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] din, input logic rd, input logic [AW-1:0] ra);
    @(negedge clk);
    resetn = rn; write = w; wr_address = wa; data_in = din; read = rd; rd_address = ra;
    if (!rn) begin
      m_out = '0;
      foreach (m_vld[i]) m_vld[i] = 1'b0;
    end else begin
      if (rd) begin
        if (BYPASS && w && (wa == ra)) m_out = din;
        else                           m_out = m_vld[ra] ? m_mem[ra] : '0;
      end
      if (w) begin
        m_mem[wa] = din;
        m_vld[wa] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name);
    logic [DW-1:0] exp;
    @(posedge clk);
    #1;
    applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no expected value queued, data_out=%h", name, data_out);
    end else begin
      exp = exp_q.pop_front();
      if (data_out !== exp) begin
        miscompares++;
        $display("FAIL %s: data_out=%h expected %h", name, data_out, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] col_exp;
    logic [DW-1:0] col_inv_exp;
    logic [DW-1:0] d;
    logic [AW-1:0] wa, ra;
    logic          rn, w, rd;

    col_exp     = BYPASS ? 64'h5555 : 64'hAAAA;
    col_inv_exp = BYPASS ? 64'h99   : 64'h0;

    resetn = 1'b0; write = 1'b0; read = 1'b0;
    wr_address = '0; rd_address = '0; data_in = '0;

    //  rn    wr  wa       din                    rd  ra       expected data_out
    add(1'b0, 0, 12'h000, 64'h0,                 0, 12'h000, 64'h0);
    add(1'b0, 0, 12'h000, 64'h0,                 0, 12'h000, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h000, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'hFFF, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h7A5, 64'h0);
    add(1'b1, 1, 12'h123, 64'hDEADBEEF_CAFEF00D, 0, 12'h000, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h123, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 1, 12'h000, 64'h1,                 1, 12'h123, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 1, 12'hFFF, 64'hFFFFFFFF_FFFFFFFF, 1, 12'h000, 64'h1);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'hFFF, 64'hFFFFFFFF_FFFFFFFF);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h000, 64'h1);
    add(1'b1, 1, 12'h050, 64'hAAAA,              0, 12'h000, 64'h1);
    add(1'b1, 1, 12'h050, 64'h5555,              1, 12'h050, col_exp);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h050, 64'h5555);
    add(1'b1, 1, 12'h400, 64'h99,                1, 12'h400, col_inv_exp);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h400, 64'h99);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h123, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 0, 12'h000, 64'h0,                 0, 12'h000, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 1, 12'h300, 64'h3333,              0, 12'h300, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 0, 12'h000, 64'h0,                 0, 12'h050, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 1, 12'h123, 64'h7,                 0, 12'h123, 64'hDEADBEEF_CAFEF00D);
    add(1'b1, 0, 12'h000, 64'h0,                 0, 12'h000, 64'hDEADBEEF_CAFEF00D);
    add(1'b0, 1, 12'h200, 64'h77,                1, 12'h000, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h123, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h200, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h300, 64'h0);
    add(1'b1, 1, 12'h123, 64'h42,                1, 12'h200, 64'h0);
    add(1'b1, 0, 12'h000, 64'h0,                 1, 12'h123, 64'h42);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].resetn, tbl[i].write, tbl[i].wa, tbl[i].din, tbl[i].read, tbl[i].ra);
      exp_q.push_back(tbl[i].exp);
      check($sformatf("vec%0d", i));
    end

    // Hand-written hold sequence: after a read, five idle cycles keep data_out.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 12'h123);
    exp_q.push_back(64'h42);
    check("hold_read");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 12'h124, 64'hBAD0 + 64'(i), 1'b0, 12'h124);
      exp_q.push_back(64'h42);
      check($sformatf("hold%0d", i));
    end

    // Random traffic concentrated on a small address window to hit collisions.
    for (int i = 0; i < 500; i++) begin
      rn = ($urandom_range(99) != 0);
      w  = 1'($urandom_range(1));
      rd = ($urandom_range(3) != 0);
      wa = ($urandom_range(9) == 0) ? AW'($urandom) : AW'($urandom_range(15));
      ra = ($urandom_range(9) == 0) ? AW'($urandom) : AW'($urandom_range(15));
      d  = {$urandom, $urandom};
      drive(rn, w, wa, d, rd, ra);
      exp_q.push_back(m_out);
      check($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
